// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: depth derivation, threshold
// legality and read-mode selectors.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  // Almost-full may sit anywhere from 1 to DEPTH; almost-empty from 0 to DEPTH-1.
  function automatic bit fifo_thresh_ok(input int afull, input int aempty, input int depth);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// WORDSIZE x DEPTH register array: one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module sync_fifo_mem #(
  parameter int WORDSIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int DEPTH    = 16
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [WORDSIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [WORDSIZE-1:0] rdata
);

  logic [WORDSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// overflow/underflow, synchronous flush and selectable FWFT read mode.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WORDSIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_THRESH  = fifo_depth(ADDRSIZE) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = FIFO_STD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                signal_write,
  input  logic [WORDSIZE-1:0] write_data,
  input  logic                signal_read,
  output logic [WORDSIZE-1:0] read_data,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);
  localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE+1)'(AEMPTY_THRESH);

  if (!fifo_thresh_ok(AFULL_THRESH, AEMPTY_THRESH, DEPTH)) begin : g_bad_thresh
    $fatal(1, "sync_fifo_flags: AFULL_THRESH/AEMPTY_THRESH out of range");
  end

  logic [ADDRSIZE-1:0] wptr, rptr;
  logic [ADDRSIZE:0]   count_q;
  logic [WORDSIZE-1:0] mem_rdata;
  logic                wr_acc, rd_acc;

  // Flags are pure decodes of the registered count, so they lag the causing edge by one cycle.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;

  // A flush swallows any same-cycle request; a full FIFO never passes a write through.
  assign wr_acc = signal_write && !full  && !clear;
  assign rd_acc = signal_read  && !empty && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (signal_write && full) overflow  <= 1'b1;
      if (signal_read && empty) underflow <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .WORDSIZE (WORDSIZE),
    .ADDRSIZE (ADDRSIZE),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (write_data),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign read_data = mem_rdata;
  end else begin : g_std
    // Output register is left alone by clear; only reset zeroes it.
    logic [WORDSIZE-1:0] rd_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        rd_q <= '0;
      else if (rd_acc) rd_q <= mem_rdata;
    end
    assign read_data = rd_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// checks both against a queue-based model of the FIFO.
module tb_sync_fifo_flags;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0, sw = 1'b0, sr = 1'b0;
  logic [7:0] wd = '0;

  logic [7:0] rd_s, rd_f;
  logic       full_s, empty_s, af_s, ae_s, ov_s, un_s;
  logic       full_f, empty_f, af_f, ae_f, ov_f, un_f;
  logic [2:0] cnt_s, cnt_f;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  bit         m_ov = 0, m_un = 0;
  logic [7:0] m_rd = '0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.WORDSIZE(8), .ADDRSIZE(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clear(clear), .signal_write(sw), .write_data(wd), .signal_read(sr),
    .read_data(rd_s), .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .count(cnt_s), .overflow(ov_s), .underflow(un_s));

  sync_fifo_flags #(.WORDSIZE(8), .ADDRSIZE(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .clear(clear), .signal_write(sw), .write_data(wd), .signal_read(sr),
    .read_data(rd_f), .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(cnt_f), .overflow(ov_f), .underflow(un_f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, "/cnt_s"}, 32'(cnt_s), 32'(n));
    chk({tag, "/cnt_f"}, 32'(cnt_f), 32'(n));
    chk({tag, "/empty"}, {30'd0, empty_s, empty_f}, {30'd0, n == 0, n == 0});
    chk({tag, "/full"},  {30'd0, full_s, full_f},   {30'd0, n == DEPTH, n == DEPTH});
    chk({tag, "/afull"}, {30'd0, af_s, af_f},       {30'd0, n >= 3, n >= 3});
    chk({tag, "/aempty"},{30'd0, ae_s, ae_f},       {30'd0, n <= 1, n <= 1});
    chk({tag, "/ovf"},   {30'd0, ov_s, ov_f},       {30'd0, m_ov, m_ov});
    chk({tag, "/unf"},   {30'd0, un_s, un_f},       {30'd0, m_un, m_un});
    chk({tag, "/rd_std"}, 32'(rd_s), 32'(m_rd));
    if (n > 0) chk({tag, "/rd_fwft"}, 32'(rd_f), 32'(q[0]));
  endtask

  // One clock with the given request; the model advances from the pre-edge occupancy.
  task automatic step(input string tag, input bit w, input logic [7:0] d, input bit r, input bit c);
    bit wacc, racc;
    sw = w; wd = d; sr = r; clear = c;
    @(posedge clk);
    wacc = w && (q.size() < DEPTH) && !c;
    racc = r && (q.size() > 0) && !c;
    if (c) begin
      q.delete();
      m_ov = 0;
      m_un = 0;
    end else begin
      if (w && q.size() == DEPTH) m_ov = 1;
      if (r && q.size() == 0)     m_un = 1;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(d);
    end
    #1;
    sw = 0; sr = 0; clear = 0;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [4];
    logic [7:0] d;
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};

    #12;
    check_all("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // fill and drain
    foreach (seq[i]) step("fill", 1, seq[i], 0, 0);
    for (int i = 0; i < 4; i++) step("drain", 0, 8'h00, 1, 0);

    // overflow at full; the dropped word must never appear
    foreach (seq[i]) step("refill", 1, seq[i], 0, 0);
    step("ovf_write", 1, 8'h55, 0, 0);
    step("ovf_wr_rd", 1, 8'h66, 1, 0);
    for (int i = 0; i < 3; i++) step("ovf_drain", 0, 8'h00, 1, 0);

    // simultaneous read/write at count 2 across pointer wrap
    d = 8'h80;
    for (int i = 0; i < 2; i++) begin step("pre2", 1, d, 0, 0); d++; end
    for (int i = 0; i < 10; i++) begin step("rw2", 1, d, 1, 0); d++; end
    for (int i = 0; i < 2; i++) step("post2", 0, 8'h00, 1, 0);

    // FWFT word visible without a read
    step("fwft_wr", 1, 8'hA5, 0, 0);
    step("fwft_rd", 0, 8'h00, 1, 0);

    // underflow, then clear beats a same-cycle write
    step("unf_rd", 0, 8'h00, 1, 0);
    step("clr_w1", 1, 8'h01, 0, 0);
    step("clr_w2", 1, 8'h02, 0, 0);
    step("clear", 1, 8'h03, 0, 1);
    step("post_clr", 0, 8'h00, 0, 0);

    // asynchronous reset at count 3, between edges
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 8'(8'hC0 + i), 0, 0);
    #2;
    rst = 1'b0;
    q.delete(); m_ov = 0; m_un = 0; m_rd = '0;
    #1;
    check_all("async_rst");
    rst = 1'b1;

    // randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow errors, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the buffer between same-clock producer/consumer stages where CDC pointer synchronisation is unnecessary.

Parameters:
- WORDSIZE, 8, data word width in bits.
- ADDRSIZE, 4, address width; DEPTH = 2**ADDRSIZE entries.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value; legal range 0..DEPTH-1.
- FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush of pointers, count and error flags.
- signal_write  input  1  write request.
- write_data  input  WORDSIZE  write word.
- signal_read  input  1  read request (pop).
- read_data  output  WORDSIZE  read word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst low, asynchronous): wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0, read_data = 0. Memory contents are not reset.
- Accepts and count:
  - Write accepted iff signal_write && !full. Read accepted iff signal_read && !empty.
  - No pass-through: a write while full is dropped even if a read is accepted in the same cycle.
  - Accepted write stores write_data at mem[wptr] and increments wptr.
  - Accepted read increments rptr.
  - Pointers are ADDRSIZE bits and wrap naturally from DEPTH-1 to 0.
  - count: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags are decoded from the registered count and change the cycle after the causing edge. Example: empty deasserts one cycle after the first write into an empty FIFO.
- Non-FWFT read:
  - read_data <= mem[rptr] on an accepted read; valid in the cycle after signal_read is sampled.
  - read_data holds its value when no read is accepted.
- FWFT read:
  - read_data = mem[rptr] combinationally (register-array read) whenever !empty.
  - An accepted read advances to the next word on the following cycle.
  - read_data is don't-care while empty.
- Errors:
  - overflow sets on the edge where signal_write && full; underflow sets on the edge where signal_read && empty.
  - Both are sticky until clear or reset.
- clear:
  - Next edge forces wptr = rptr = count = 0 and clears overflow/underflow.
  - Overrides any write or read in the same cycle; those requests are dropped and flag no error.
  - read_data in non-FWFT mode is unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk.
- Elaboration: out-of-range AFULL_THRESH / AEMPTY_THRESH is a fatal elaboration error.

Decomposition:
- Package fifo_pkg:
  - DEPTH derivation function.
  - Threshold range-check function.
  - FWFT mode constants (FIFO_STD = 0, FIFO_FWFT = 1).
- Sub-module sync_fifo_mem: WORDSIZE x DEPTH register array with a write port and a combinational read port.
- Pointers, count, flags and the read register live in the top module.

Test Plan (all with WORDSIZE = 8, ADDRSIZE = 2, so DEPTH = 4; AFULL_THRESH = 3, AEMPTY_THRESH = 1):
1. Fill and drain: write 0x11, 0x22, 0x33, 0x44, then read 4 times (FWFT = 0).
   - count steps 1..4; almost_full at count 3; full at count 4.
   - read_data is 0x11..0x44 in order, each one cycle after its read.
   - empty = 1 at the end.
2. Overflow: at full, write 0x55 for one cycle.
   - overflow = 1 and stays set; count = 4.
   - The subsequent four reads return 0x11..0x44 (0x55 was never stored).
3. Simultaneous read and write at count 2 for 10 cycles with incrementing data.
   - count stays 2.
   - Output order is preserved across pointer wrap-around.
4. FWFT = 1: write 0xA5 into an empty FIFO.
   - Next cycle: empty = 0 and read_data = 0xA5 with no read issued.
   - A read makes empty = 1 one cycle later.
5. Underflow, then clear:
   - Read while empty: underflow = 1.
   - Write 0x01, 0x02, then assert clear together with signal_write: count = 0, empty = 1, underflow = 0, and the write is dropped.
6. Asynchronous reset at count 3, mid-clock-cycle: count = 0, empty = 1 and all flags return to reset values before the next clk edge.
